// File: rtl/uart_pkg.sv
// Shared types and frame constants for the 8N1 UART core.
package uart_pkg;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   FRAME_BITS = 10;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: loads a full or half bit period and flags terminal count.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic load_i,
    input  logic half_i,
    output logic tick_o
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] FULL_LOAD = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] HALF_LOAD = W'(CLKS_PER_BIT / 2 - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Loading N-1 makes the tick land exactly N cycles after the load edge.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = half_i ? HALF_LOAD : FULL_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART: independent TX and RX FSMs, each paced by its own bit timer.
module uart_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_rx_enable,
    input  logic                 tx_rx_start,
    output logic                 tx_out,
    input  logic                 rx_in,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic [DATA_BITS-1:0] rx_received_data,
    output logic                 valid,
    output logic                 busy
);

    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    tx_state_t              tx_state_q;
    logic [DATA_BITS-1:0]   tx_shift_q;
    logic [IW-1:0]          tx_idx_q;
    logic                   tx_out_q, busy_q;
    logic                   tx_tick, tx_load;

    rx_state_t              rx_state_q;
    logic [1:0]             rx_sync_q;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_data_q;
    logic [IW-1:0]          rx_idx_q;
    logic                   valid_q, ferr_q;
    logic                   rx_s, rx_tick, rx_load, rx_half;

    assign rx_s = rx_sync_q[1];

    assign tx_load = (tx_state_q == TX_IDLE) ? (tx_rx_start && !busy_q)
                                             : (tx_tick && tx_state_q != TX_STOP);

    assign rx_half = (rx_state_q == RX_IDLE);
    assign rx_load = ((rx_state_q == RX_IDLE)  && !rx_s) ||
                     ((rx_state_q == RX_START) && rx_tick && !rx_s) ||
                     ((rx_state_q == RX_DATA)  && rx_tick);

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (tx_rx_enable),
        .load_i (tx_load),
        .half_i (1'b0),
        .tick_o (tx_tick)
    );

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (tx_rx_enable),
        .load_i (rx_load),
        .half_i (rx_half),
        .tick_o (rx_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_idx_q   <= '0;
            tx_out_q   <= STOP_BIT;
            busy_q     <= 1'b0;
        end else if (tx_rx_enable) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_idx_q   <= '0;
            tx_out_q   <= STOP_BIT;
            busy_q     <= 1'b0;
        end else begin
            case (tx_state_q)
                TX_IDLE: if (tx_rx_start && !busy_q) begin
                    tx_shift_q <= tx_data;
                    tx_state_q <= TX_START;
                    busy_q     <= 1'b1;
                    tx_out_q   <= START_BIT;
                end
                TX_START: if (tx_tick) begin
                    tx_out_q   <= tx_shift_q[0];
                    tx_shift_q <= tx_shift_q >> 1;
                    tx_idx_q   <= '0;
                    tx_state_q <= TX_DATA;
                end
                TX_DATA: if (tx_tick) begin
                    if (tx_idx_q == LAST_IDX) begin
                        tx_out_q   <= STOP_BIT;
                        tx_state_q <= TX_STOP;
                    end else begin
                        tx_out_q   <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_idx_q   <= tx_idx_q + 1'b1;
                    end
                end
                TX_STOP: if (tx_tick) begin
                    tx_state_q <= TX_IDLE;
                    busy_q     <= 1'b0;
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    // In STOP the timer is not reloaded, so its tick stays high while a
    // framing error waits for the line to return to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_sync_q  <= 2'b11;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_idx_q   <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else if (tx_rx_enable) begin
            rx_state_q <= RX_IDLE;
            rx_sync_q  <= 2'b11;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_idx_q   <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], rx_in};
            valid_q   <= 1'b0;
            case (rx_state_q)
                RX_IDLE: if (!rx_s) rx_state_q <= RX_START;
                RX_START: if (rx_tick) begin
                    if (!rx_s) begin
                        rx_idx_q   <= '0;
                        rx_state_q <= RX_DATA;
                    end else begin
                        rx_state_q <= RX_IDLE;
                    end
                end
                RX_DATA: if (rx_tick) begin
                    rx_shift_q <= {rx_s, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_idx_q == LAST_IDX) rx_state_q <= RX_STOP;
                    else                      rx_idx_q   <= rx_idx_q + 1'b1;
                end
                RX_STOP: if (rx_tick) begin
                    if (rx_s) begin
                        if (!ferr_q) begin
                            rx_data_q <= rx_shift_q;
                            valid_q   <= 1'b1;
                        end
                        ferr_q     <= 1'b0;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        ferr_q <= 1'b1;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign tx_out           = tx_out_q;
    assign busy             = busy_q;
    assign valid            = valid_q;
    assign rx_received_data = rx_data_q;

endmodule

// File: tb/tb_uart_core.sv
// Directed and randomized bench for uart_core with TX->RX loopback and a frame-level reference model.
module tb_uart_core;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n, tx_rx_enable, tx_rx_start, rx_drv, loop_en;
    logic [7:0] tx_data;
    logic       rx_in;
    logic       tx_out, valid, busy;
    logic [7:0] rx_received_data;

    assign rx_in = loop_en ? tx_out : rx_drv;

    uart_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .tx_rx_enable     (tx_rx_enable),
        .tx_rx_start      (tx_rx_start),
        .tx_out           (tx_out),
        .rx_in            (rx_in),
        .tx_data          (tx_data),
        .rx_received_data (rx_received_data),
        .valid            (valid),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int         passed = 0, total = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    int         vrun = 0, vmax = 0, bcnt = 0, last_busy = 0;

    // Monitor: collects every valid pulse and measures pulse / busy widths.
    always @(negedge clk) begin
        if (valid) begin
            got_q.push_back(rx_received_data);
            vrun++;
            if (vrun > vmax) vmax = vrun;
        end else begin
            vrun = 0;
        end
        if (busy) begin
            bcnt++;
        end else if (bcnt != 0) begin
            last_busy = bcnt;
            bcnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Serial level of bit slot k in an 8N1 frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0)      return START_BIT;
        else if (k <= 8) return b[k-1];
        else             return STOP_BIT;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("tx_idle_timeout", busy, 0);
    endtask

    task automatic wait_rx(input string tag, input int n);
        int c = 0;
        while (got_q.size() < n && c < 400) begin
            @(negedge clk);
            c++;
        end
        chk(tag, got_q.size(), n);
    endtask

    task automatic compare_rx(input string tag);
        logic [7:0] e, g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            chk(tag, g, e);
            last_good = e;
        end
        got_q.delete();
    endtask

    // Sends b and checks tx_out every cycle of the 160-cycle frame; poke >= 0
    // issues an ignored start with different data at that cycle.
    task automatic tx_frame(input logic [7:0] b, input int poke, output int mism);
        wait_idle();
        tx_data     = b;
        tx_rx_start = 1'b1;
        @(negedge clk);
        tx_rx_start = 1'b0;
        mism = 0;
        exp_q.push_back(b);
        for (int k = 0; k < FRAME_BITS * CPB; k++) begin
            if (tx_out !== frame_bit(b, k / CPB)) mism++;
            if (k == poke) begin
                tx_data     = 8'h11;
                tx_rx_start = 1'b1;
            end else begin
                tx_rx_start = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop);
        for (int k = 0; k < FRAME_BITS; k++) begin
            rx_drv = (k == FRAME_BITS - 1) ? stop : frame_bit(b, k);
            repeat (CPB) @(negedge clk);
        end
        if (!stop) repeat (CPB) @(negedge clk);
        rx_drv = 1'b1;
    endtask

    initial begin
        int         mism, msum;
        logic [7:0] b;

        rst_n = 1'b0; tx_rx_enable = 1'b0; tx_rx_start = 1'b0;
        tx_data = 8'h00; rx_drv = 1'b1; loop_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx_out", tx_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_rx_data", rx_received_data, 8'h00);

        rst_n = 1'b1; tx_rx_enable = 1'b1;
        repeat (2) @(negedge clk);
        chk("clr_tx_out", tx_out, 1);
        chk("clr_busy", busy, 0);
        chk("clr_valid", valid, 0);
        chk("clr_rx_data", rx_received_data, 8'h00);
        tx_rx_enable = 1'b0;
        @(negedge clk);

        // Single frame 0xA5 with exact waveform and busy width.
        got_q.delete(); vmax = 0;
        tx_frame(8'hA5, -1, mism);
        chk("a5_wave_mismatches", mism, 0);
        chk("a5_busy_after_frame", busy, 0);
        repeat (5) @(negedge clk);
        chk("a5_busy_len", last_busy, 160);
        wait_rx("a5_rx_count", 1);
        compare_rx("a5_rx_data");

        // Back-to-back loopback: directed bytes then random ones.
        vmax = 0; msum = 0;
        tx_frame(8'h3C, -1, mism); msum += mism;
        tx_frame(8'hFF, -1, mism); msum += mism;
        tx_frame(8'h00, -1, mism); msum += mism;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            tx_frame(b, -1, mism);
            msum += mism;
        end
        chk("loop_wave_mismatches", msum, 0);
        wait_rx("loop_rx_count", 7);
        chk("loop_valid_width", vmax, 1);
        compare_rx("loop_rx_data");

        // Start while busy is ignored and data changes have no effect.
        tx_frame(8'h55, 40, mism);
        chk("busy_start_wave", mism, 0);
        repeat (40) @(negedge clk);
        chk("busy_start_len", last_busy, 160);
        chk("busy_start_not_queued", busy, 0);
        wait_rx("busy_start_rx_count", 1);
        compare_rx("busy_start_rx_data");

        // Glitch on the RX line.
        loop_en = 1'b0; rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_no_valid", got_q.size(), 0);

        // Framing error leaves the last good byte in place.
        rx_frame(8'h7E, 1'b0);
        repeat (40) @(negedge clk);
        chk("ferr_no_valid", got_q.size(), 0);
        chk("ferr_data_held", rx_received_data, last_good);

        // A good externally driven frame recovers after the error.
        b = 8'($urandom);
        exp_q.push_back(b);
        rx_frame(b, 1'b1);
        wait_rx("ext_rx_count", 1);
        compare_rx("ext_rx_data");

        // Abort during data bit 3 (bit 3 forced 0 so the line is low there).
        loop_en = 1'b1;
        b = 8'($urandom) & 8'hF7;
        wait_idle();
        tx_data = b; tx_rx_start = 1'b1;
        @(negedge clk);
        tx_rx_start = 1'b0;
        repeat (70) @(negedge clk);
        chk("abort_pre_line", tx_out, 0);
        tx_rx_enable = 1'b1;
        @(negedge clk);
        chk("abort_tx_out", tx_out, 1);
        chk("abort_busy", busy, 0);
        tx_rx_enable = 1'b0;
        repeat (200) @(negedge clk);
        chk("abort_no_valid", got_q.size(), 0);

        tx_frame(8'h81, -1, mism);
        chk("post_abort_wave", mism, 0);
        wait_rx("post_abort_rx_count", 1);
        compare_rx("post_abort_rx_data");
        chk("post_abort_rx_hold", rx_received_data, 8'h81);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Full-duplex 8N1 UART: one transmitter and one receiver, both timed by a common parameterised bit-period counter scheme.
- TX serialises a parallel byte on tx_out when started. RX deserialises rx_in and pulses valid with the received byte.
- Sits between a byte-wide host interface and the serial pins. The bench drives both sides through its interface and loops tx_out back to rx_in.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be ≥ 4 and even.
- DATA_BITS, 8, data bits per frame; the ports below assume 8.

Ports:
- clk  input  1  system clock, rising edge; 100 MHz in bench.
- rst_n  input  1  asynchronous active-low reset.
- tx_rx_enable  input  1  synchronous soft clear, active high; while high, TX and RX are forced to IDLE with outputs at reset values.
- tx_rx_start  input  1  one-cycle request to transmit tx_data.
- tx_out  output  1  serial TX line, idle high.
- rx_in  input  1  serial RX line, asynchronous, idle high.
- tx_data  input  8  byte to transmit, sampled when a start is accepted.
- rx_received_data  output  8  last correctly received byte.
- valid  output  1  one-cycle pulse when rx_received_data is updated.
- busy  output  1  high while a TX frame is in progress.

Behaviour:
- Reset (rst_n=0, asynchronous) or tx_rx_enable=1 (synchronous) sets: tx_out=1, busy=0, valid=0, rx_received_data=0x00, both FSMs in IDLE, all counters 0.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity. Each bit lasts exactly CLKS_PER_BIT cycles.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a clock edge where tx_rx_start=1 and busy=0, latch tx_data, go to START, set busy=1 and tx_out=0. Both change on that same edge.
  - START: lasts CLKS_PER_BIT cycles, then go to DATA.
  - DATA: drives bit i for CLKS_PER_BIT cycles, i=0..7, then go to STOP.
  - STOP: drives tx_out=1 for CLKS_PER_BIT cycles, then return to IDLE with busy=0.
  - Total busy time is exactly 10*CLKS_PER_BIT cycles.
  - tx_rx_start while busy=1 is ignored; it is not queued.
  - A new start is accepted on the first cycle busy=0, so back-to-back frames have no idle gap.
  - Changes on tx_data during a frame have no effect.
- RX input: rx_in passes through a 2-flop synchronizer (preset to 1) before any use.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a synchronized low level moves the FSM to START.
  - START: wait CLKS_PER_BIT/2 cycles, then re-sample. If still low, go to DATA. If high, treat it as a glitch and return to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles, at mid-bit, shifting LSB first, 8 samples.
  - STOP: after CLKS_PER_BIT more cycles, sample the line.
    - If 1: load rx_received_data with the shift register, pulse valid for exactly one cycle, go to IDLE.
    - If 0: framing error. Discard the byte, no valid, rx_received_data unchanged, wait for the line to return high, then go to IDLE.
  - The receiver returns to IDLE at mid-stop-bit, so back-to-back frames are received.
- rx_received_data holds its value until the next good frame.
- TX and RX are fully independent; simultaneous activity is allowed.
- Assertion of tx_rx_enable or rst_n mid-frame aborts both directions immediately:
  - tx_out returns to 1 and busy to 0;
  - no valid is produced for the partial frame.

Decomposition:
- uart_pkg holds:
  - tx_state_t and rx_state_t enums {IDLE, START, DATA, STOP};
  - constants START_BIT=0, STOP_BIT=1, FRAME_BITS=10.
- One natural sub-module, uart_bit_timer: a down-counter with a load value (CLKS_PER_BIT or CLKS_PER_BIT/2) and a tick output. It is instantiated once in TX and once in RX.
- The synchronizer and both FSMs live in uart_core.

Test Plan:
- Reset/soft-clear: rst_n=0, then tx_rx_enable=1 for 2 cycles, then release. Required: tx_out=1, busy=0, valid=0, rx_received_data=0x00.
- Single TX: start with tx_data=0xA5.
  - tx_out must follow 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles.
  - busy must be high for exactly 160 cycles.
- Loopback: tx_out tied to rx_in, send 0x3C, 0xFF, 0x00 back-to-back. Required: three valid pulses with data 0x3C, 0xFF, 0x00, each valid exactly 1 cycle wide.
- Start while busy: pulse tx_rx_start with 0x11 mid-frame of 0x55. Required: only 0x55 is transmitted and the busy duration is unchanged.
- RX glitch and framing error:
  - A 3-cycle low pulse on rx_in produces no valid.
  - A frame for 0x7E with the stop bit forced 0 produces no valid and leaves rx_received_data at its previous value.
- Mid-frame abort: assert tx_rx_enable during data bit 3. Required: tx_out=1 and busy=0 on the next cycle, no valid, then a subsequent frame for 0x81 is received correctly.
